ex_dp_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 32-bit ce/data_valid datapath (ex_module2-class) among N_REQ requesters.

---
 rtl/ex_arb_pkg.sv | 23 ++
 rtl/ex_rr_picker.sv | 36 +++
 rtl/ex_dp_arbiter.sv | 118 +++++++++++
 tb/tb_ex_dp_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_arb_pkg.sv
// Shared state encoding, default widths and a width helper for the datapath arbiter slice.
package ex_arb_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Bits needed to index 'value' distinct items (value >= 2).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/ex_rr_picker.sv
// Round-robin selector: rotate requests so rr_ptr is at bit 0, take the lowest set bit,
// then rotate the winner back to its absolute index.
module ex_rr_picker
    import ex_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int IDX_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [IDX_W-1:0]   rot_idx;
    logic [IDX_W:0]     sum;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        doubled = {req, req};
        rotated = doubled[rr_ptr +: N_REQ];
        any     = |req;
        rot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) rot_idx = IDX_W'(i);
        end
        sum = {1'b0, rot_idx} + {1'b0, rr_ptr};
        if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
        index = sum[IDX_W-1:0];
        grant = any ? (N_REQ'(1) << index) : '0;
    end

endmodule

// File: rtl/ex_dp_arbiter.sv
// Round-robin arbiter sharing one ce/data_valid datapath among N_REQ requesters,
// with a bounded wait for the result and a timeout error response.
module ex_dp_arbiter
    import ex_arb_pkg::*;
#(
    parameter  int N_REQ   = N_REQ_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int IDX_W   = clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic                    dp_ce,
    output logic [DATA_W-1:0]       dp_data_in,
    input  logic                    dp_data_valid,
    input  logic [DATA_W-1:0]       dp_data_out,
    output logic                    busy,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    err_sticky
);

    localparam int               CNT_W     = clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] wait_cnt;
    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_index;
    logic             pick_any;
    logic             timed_out;

    ex_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .index  (pick_index),
        .any    (pick_any)
    );

    // Gated with rst so nothing is offered while the block is held in reset.
    assign req_ready = (state == IDLE && rst) ? pick_grant : '0;
    assign dp_ce     = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign timed_out = (state == WAIT) && !dp_data_valid && (wait_cnt == CNT_LIMIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any) state_next = ISSUE;
            ISSUE:   state_next = dp_data_valid ? RESP : WAIT;
            WAIT:    if (dp_data_valid || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            wait_cnt   <= '0;
            grant_id   <= '0;
            dp_data_in <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            rsp_valid <= (state_next == RESP) ? (N_REQ'(1) << grant_id) : '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id   <= pick_index;
                        dp_data_in <= req_data[pick_index*DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    wait_cnt <= CNT_W'(1);
                    if (dp_data_valid) begin
                        rsp_data <= dp_data_out;
                        rsp_err  <= 1'b0;
                    end
                end
                WAIT: begin
                    // A result arriving on the limit cycle still wins over the timeout.
                    if (dp_data_valid) begin
                        rsp_data <= dp_data_out;
                        rsp_err  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        err_sticky <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_dp_arbiter.sv
// Directed self-checking bench for ex_dp_arbiter with a small behavioural datapath
// whose result is the two's-complement negation of its operand.
module tb_ex_dp_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           dp_ce;
    logic [W-1:0]   dp_data_in;
    logic           dp_data_valid;
    logic [W-1:0]   dp_data_out;
    logic           busy;
    logic [1:0]     grant_id;
    logic           err_sticky;

    int checks;
    int errors;
    int cyc;

    // Datapath model: result valid dp_delay cycles after ce (0 = same cycle, <0 = never).
    int           dp_delay;
    logic         spur_valid;
    logic [W-1:0] spur_data;
    logic [15:0]  ce_hist;
    logic         model_valid;

    ex_dp_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .dp_ce         (dp_ce),
        .dp_data_in    (dp_data_in),
        .dp_data_valid (dp_data_valid),
        .dp_data_out   (dp_data_out),
        .busy          (busy),
        .grant_id      (grant_id),
        .err_sticky    (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ce_hist <= '0;
        else      ce_hist <= {ce_hist[14:0], dp_ce};
    end

    always_comb begin
        model_valid = 1'b0;
        if (dp_delay == 0)                      model_valid = dp_ce;
        else if (dp_delay > 0 && dp_delay <= 16) model_valid = ce_hist[dp_delay-1];
    end

    assign dp_data_valid = model_valid | spur_valid;
    assign dp_data_out   = spur_valid ? spur_data : (32'd0 - dp_data_in);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        while (rsp_valid == '0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("rsp_arrived", {63'd0, |rsp_valid}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_order [5];
        logic [31:0] exp_rsp   [5];
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_rsp   = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFFF};

        checks     = 0;
        errors     = 0;
        dp_delay   = 0;
        spur_valid = 1'b0;
        spur_data  = '0;
        rst        = 1'b0;
        req_valid  = 4'b1111;
        req_data   = {32'd4, 32'd3, 32'd2, 32'd1};

        // Reset state, with all requesters already asserting valid
        step();
        check("rst_req_ready",  req_ready,  0);
        check("rst_rsp_valid",  rsp_valid,  0);
        check("rst_rsp_data",   rsp_data,   0);
        check("rst_rsp_err",    rsp_err,    0);
        check("rst_dp_ce",      dp_ce,      0);
        check("rst_dp_data_in", dp_data_in, 0);
        check("rst_grant_id",   grant_id,   0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_busy",       busy,       0);

        // Test 2: all requesters valid from reset, result valid in ISSUE
        step();
        rst = 1'b1;
        #1;
        check("t2_first_ready", req_ready, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            wait_rsp(10, cyc);
            check("t2_rsp_valid", rsp_valid, exp_order[i]);
            check("t2_grant_id",  grant_id,  i % 4);
            check("t2_rsp_data",  rsp_data,  exp_rsp[i]);
            check("t2_rsp_err",   rsp_err,   0);
            if (i == 4) req_valid = '0;
            step();
        end
        check("t2_idle", busy, 0);

        // Test 1: single request from requester 2, result one cycle after ce
        req_valid = 4'b0100;
        req_data[2*W +: W] = 32'h0000_0005;
        dp_delay = 1;
        #1;
        check("t1_req_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        check("t1_dp_ce",      dp_ce,      1);
        check("t1_dp_data_in", dp_data_in, 32'h0000_0005);
        check("t1_grant_id",   grant_id,   2);
        check("t1_ready_off",  req_ready,  0);
        wait_rsp(10, cyc);
        check("t1_latency",    cyc,        2);
        check("t1_rsp_valid",  rsp_valid,  4'b0100);
        check("t1_rsp_data",   rsp_data,   32'hFFFF_FFFB);
        check("t1_rsp_err",    rsp_err,    0);
        check("t1_sticky",     err_sticky, 0);
        step();
        check("t1_strobe_1cyc", rsp_valid, 0);
        check("t1_data_hold",   rsp_data,  32'hFFFF_FFFB);

        // Test 3: datapath never answers -> timeout after 16 ISSUE+WAIT cycles
        req_valid = 4'b0001;
        req_data[0*W +: W] = 32'h0000_1234;
        dp_delay = -1;
        #1;
        check("t3_req_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        wait_rsp(40, cyc);
        check("t3_occupancy", cyc,        16);
        check("t3_rsp_valid", rsp_valid,  4'b0001);
        check("t3_rsp_data",  rsp_data,   0);
        check("t3_rsp_err",   rsp_err,    1);
        check("t3_sticky",    err_sticky, 1);
        step();
        spur_valid = 1'b1;
        spur_data  = 32'h0000_5555;
        step();
        spur_valid = 1'b0;
        check("t3_late_busy",  busy,      0);
        check("t3_late_rsp",   rsp_valid, 0);
        check("t3_late_data",  rsp_data,  0);
        check("t3_late_err",   rsp_err,   1);
        req_valid = 4'b0010;
        req_data[1*W +: W] = 32'h0000_0007;
        dp_delay = 0;
        wait_rsp(10, cyc);
        req_valid = '0;
        check("t3_next_valid",  rsp_valid,  4'b0010);
        check("t3_next_data",   rsp_data,   32'hFFFF_FFF9);
        check("t3_next_err",    rsp_err,    0);
        check("t3_next_sticky", err_sticky, 1);
        repeat (20) step();
        check("t3_quiet", busy, 0);

        // Test 4: result arrives on the cycle the counter reaches TIMEOUT
        req_valid = 4'b1000;
        req_data[3*W +: W] = 32'h0000_0100;
        dp_delay = 15;
        #1;
        check("t4_req_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        wait_rsp(40, cyc);
        check("t4_occupancy", cyc,        16);
        check("t4_rsp_valid", rsp_valid,  4'b1000);
        check("t4_rsp_data",  rsp_data,   32'hFFFF_FF00);
        check("t4_rsp_err",   rsp_err,    0);
        check("t4_sticky",    err_sticky, 1);
        step();

        // Test 6: spurious negative result in IDLE is ignored
        dp_delay   = 0;
        spur_valid = 1'b1;
        spur_data  = 32'hFFFF_FFF0;
        step();
        spur_valid = 1'b0;
        check("t6_busy",      busy,      0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_rsp_data",  rsp_data,  32'hFFFF_FF00);
        req_valid = 4'b0001;
        req_data[0*W +: W] = 32'h0000_0009;
        #1;
        check("t6_wrap_ready", req_ready, 4'b0001);
        wait_rsp(10, cyc);
        req_valid = '0;
        check("t6_rsp_valid2", rsp_valid, 4'b0001);
        check("t6_rsp_data2",  rsp_data,  32'hFFFF_FFF7);
        check("t6_rsp_err2",   rsp_err,   0);
        step();

        // Test 5: reset pulsed during WAIT
        req_valid = 4'b0010;
        req_data[1*W +: W] = 32'h0000_0042;
        dp_delay = -1;
        step();
        req_valid = '0;
        check("t5_grant_id", grant_id, 1);
        step();
        step();
        rst = 1'b0;
        #1;
        check("t5_req_ready",  req_ready,  0);
        check("t5_rsp_valid",  rsp_valid,  0);
        check("t5_rsp_data",   rsp_data,   0);
        check("t5_rsp_err",    rsp_err,    0);
        check("t5_dp_ce",      dp_ce,      0);
        check("t5_dp_data_in", dp_data_in, 0);
        check("t5_grant_id0",  grant_id,   0);
        check("t5_sticky",     err_sticky, 0);
        check("t5_busy",       busy,       0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_rsp", rsp_valid, 0);
        end
        req_valid = 4'b1001;
        req_data[0*W +: W] = 32'h0000_0003;
        dp_delay = 0;
        rst = 1'b1;
        #1;
        check("t5_ptr_reset", req_ready, 4'b0001);
        wait_rsp(10, cyc);
        req_valid = '0;
        check("t5_rsp_valid2", rsp_valid, 4'b0001);
        check("t5_rsp_data2",  rsp_data,  32'hFFFF_FFFD);
        check("t5_rsp_err2",   rsp_err,   0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
